// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone grant scheduler: CTI codes, FSM states
// and a one-hot helper sized for the largest supported master count.
package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int MAX_NM = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_e;

  // One-hot decode of a master index; callers truncate to their NM.
  function automatic logic [MAX_NM-1:0] onehot(input logic [2:0] idx);
    logic [MAX_NM-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wb_rr_pick #(
  parameter  int NM = 4,
  localparam int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    int j;
    idx_o = last_i;
    vld_o = 1'b0;
    j     = 0;
    for (int i = NM; i >= 1; i--) begin
      j = (int'(last_i) + i) % NM;
      if (req_i[j]) begin
        idx_o = IW'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_grant_sched.sv
// Round-robin owner scheduler for a shared Wishbone slave, with a burst-aligned
// fairness quantum and a stalled-strobe watchdog.
module wb_grant_sched
  import wb_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int QUANTUM = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NM-1:0]         cyc_i,
  input  logic [NM-1:0]         stb_i,
  input  logic [3*NM-1:0]       cti_i,
  input  logic                  slv_ack_i,
  output logic [$clog2(NM)-1:0] owner_o,
  output logic [NM-1:0]         gnt_o,
  output logic                  busy_o,
  output logic [NM-1:0]         tmo_err_o,
  output logic [7:0]            tmo_cnt_o
);

  localparam int IW = $clog2(NM);
  // QUANTUM=0 still needs a 1-bit counter so the logic stays well formed.
  localparam int AW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] QMAX = AW'(QUANTUM);
  localparam logic [AW-1:0] QLIM = AW'((QUANTUM > 0) ? QUANTUM - 1 : 0);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NM-1:0]   gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [NM-1:0]   tmo_err_q, tmo_err_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [NM-1:0]   own_mask;
  logic [NM-1:0]   pick_mask;
  logic [2:0]      cti_own;
  logic            cyc_own;
  logic            stb_own;
  logic            eob_own;
  logic            others_req;
  logic            preempt;
  logic            expire;

  // Both IDLE and HANDOFF rearbitrate from the last owner, so one picker serves both.
  wb_rr_pick #(.NM(NM)) u_pick (
    .req_i  (cyc_i),
    .last_i (owner_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // Decode of the current owner's bus signals and the GRANT exit conditions.
  always_comb begin
    own_mask   = NM'(onehot(3'(owner_q)));
    pick_mask  = NM'(onehot(3'(pick_idx)));
    cti_own    = cti_i[3*int'(owner_q) +: 3];
    cyc_own    = cyc_i[owner_q];
    stb_own    = stb_i[owner_q];
    eob_own    = (cti_own == CTI_CLASSIC) || (cti_own == CTI_EOB);
    others_req = |(cyc_i & ~own_mask);
    preempt    = (QUANTUM != 0) && (ack_cnt_q >= QLIM) && slv_ack_i &&
                 eob_own && others_req;
    // An ack in the expiry cycle rescues the transfer.
    expire     = stb_own && !slv_ack_i && (wait_cnt_q == TLIM);
  end

  // Next-state and registered-output logic for the IDLE/GRANT/HANDOFF FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    tmo_err_d  = '0;
    tmo_cnt_d  = tmo_cnt_q;
    ack_cnt_d  = '0;
    wait_cnt_d = '0;
    unique case (state_q)
      IDLE, HANDOFF: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          gnt_d   = pick_mask;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        gnt_d     = own_mask;
        ack_cnt_d = ack_cnt_q;
        if (slv_ack_i && (ack_cnt_q != QMAX)) begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
        if (stb_own && !slv_ack_i) begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
        // Release outranks preemption and expiry; all three share the same handoff.
        if (!cyc_own || preempt || expire) begin
          if (cyc_own && !preempt) begin
            tmo_err_d = own_mask;
            if (tmo_cnt_q != 8'hFF) begin
              tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
          end
          state_d    = HANDOFF;
          gnt_d      = '0;
          ack_cnt_d  = '0;
          wait_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |gnt_d;
  end

  // State and output registers; reset drops the grant without an error pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      tmo_err_q  <= '0;
      tmo_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign owner_o   = owner_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign tmo_err_o = tmo_err_q;
  assign tmo_cnt_o = tmo_cnt_q;

endmodule

// File: tb/tb_wb_grant_sched.sv
// Bench for wb_grant_sched: NM=4, QUANTUM=4, TIMEOUT=8.
module tb_wb_grant_sched;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cyc = '0;
  logic [3:0]  stb = '0;
  logic [2:0]  cti_m [4];
  logic [11:0] cti;
  logic        ack = 1'b0;
  logic [1:0]  owner;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  err;
  logic [7:0]  tcnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_gnt = '0;

  assign cti = {cti_m[3], cti_m[2], cti_m[1], cti_m[0]};

  wb_grant_sched #(.NM(4), .QUANTUM(4), .TIMEOUT(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cyc_i     (cyc),
    .stb_i     (stb),
    .cti_i     (cti),
    .slv_ack_i (ack),
    .owner_o   (owner),
    .gnt_o     (gnt),
    .busy_o    (busy),
    .tmo_err_o (err),
    .tmo_cnt_o (tcnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every change of gnt_o must match the next queued value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0;
      end else if (gnt !== prev_gnt) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected gnt=%b prev=%b (no change expected)", gnt, prev_gnt);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (gnt !== e) begin
            errors++;
            $display("FAIL sb_gnt got=%b exp=%b", gnt, e);
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0 || err !== 4'b0 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset gnt=%b busy=%b owner=%0d err=%b cnt=%0d exp all zero", gnt, busy, owner, err, tcnt);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle gnt=%b owner=%0d exp 0000/0", gnt, owner);
    end
  endtask

  task automatic test_rr_order();
    cyc = 4'b1000;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0000);
    step();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_m3 gnt=%b owner=%0d busy=%b exp 1000/3/1", gnt, owner, busy);
    end
    cyc = 4'b0000;
    step();
    step();
    cyc = 4'b0101;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    step();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL rr_wrap gnt=%b owner=%0d exp 0001/0", gnt, owner);
    end
    step();
    cyc = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_dead gnt=%b busy=%b exp 0000/0", gnt, busy);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL rr_next gnt=%b owner=%0d exp 0100/2", gnt, owner);
    end
    cyc = 4'b0000;
    step();
    step();
  endtask

  task automatic test_burst_preempt();
    cyc = 4'b0010;
    stb = 4'b0010;
    cti_m[1] = CTI_INCR;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL burst_grant gnt=%b exp 0010", gnt);
    end
    cyc = 4'b1010;
    for (int b = 1; b <= 16; b++) begin
      cti_m[1] = (b == 16) ? CTI_EOB : CTI_INCR;
      ack = 1'b1;
      step();
      if (b == 4 || b == 15 || b == 16) begin
        checks++;
        if (gnt !== ((b == 16) ? 4'b0000 : 4'b0010)) begin
          errors++;
          $display("FAIL burst_beat%0d gnt=%b exp %b", b, gnt, (b == 16) ? 4'b0000 : 4'b0010);
        end
      end
    end
    ack = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL preempt_next gnt=%b owner=%0d exp 1000/3", gnt, owner);
    end
    cyc = 4'b0010;
    step();
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL preempt_resume gnt=%b exp 0010", gnt);
    end
    cyc = 4'b0000;
    stb = 4'b0000;
    cti_m[1] = CTI_CLASSIC;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int bad;
    cyc = 4'b0001;
    stb = 4'b0001;
    cti_m[0] = CTI_CLASSIC;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    step();
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL single_grant gnt=%b owner=%0d exp 0001/0", gnt, owner);
    end
    bad = 0;
    ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt !== 4'b0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_no_preempt dead_cycles=%0d exp 0", bad);
    end
    ack = 1'b0;
    cyc = 4'b0000;
    stb = 4'b0000;
    step();
    step();
  endtask

  task automatic test_watchdog();
    cyc = 4'b0100;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    step();
    cyc = 4'b0101;
    stb = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) begin
        checks++;
        if (err !== 4'b0000 || gnt !== 4'b0100) begin
          errors++;
          $display("FAIL wdog_early k=%0d err=%b gnt=%b exp 0000/0100", k, err, gnt);
        end
      end
    end
    checks++;
    if (err !== 4'b0100 || tcnt !== 8'd1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL wdog_fire err=%b cnt=%0d gnt=%b exp 0100/1/0000", err, tcnt, gnt);
    end
    cyc = 4'b0001;
    stb = 4'b0000;
    step();
    checks++;
    if (err !== 4'b0000 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wdog_after err=%b gnt=%b exp 0000/0001", err, gnt);
    end
    cyc = 4'b0000;
    step();
    step();
  endtask

  task automatic test_ack_wins();
    int seen;
    cyc = 4'b0100;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    step();
    stb = 4'b0100;
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (err !== 4'b0) seen++;
    end
    ack = 1'b1;
    step();
    if (err !== 4'b0) seen++;
    ack = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (err !== 4'b0) seen++;
    end
    checks++;
    if (seen != 0 || tcnt !== 8'd1 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL ack_wins err_cycles=%0d cnt=%0d gnt=%b exp 0/1/0100", seen, tcnt, gnt);
    end
    cyc = 4'b0000;
    stb = 4'b0000;
    step();
    checks++;
    if (err !== 4'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL release_no_err err=%b gnt=%b exp 0000/0000", err, gnt);
    end
    step();
  endtask

  task automatic test_tmo_saturate();
    int expc;
    bit got;
    expc = 1;
    for (int i = 0; i < 300; i++) begin
      cyc = 4'b0100;
      stb = 4'b0100;
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0000);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (err === 4'b0100) got = 1'b1;
      end
      if (expc < 255) expc++;
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL sat_wait iter=%0d no err pulse within 20 cycles", i);
      end
      if (i == 99 || i == 299) begin
        checks++;
        if (tcnt !== 8'(expc)) begin
          errors++;
          $display("FAIL sat_cnt iter=%0d cnt=%0d exp %0d", i, tcnt, expc);
        end
      end
      cyc = 4'b0000;
      stb = 4'b0000;
      step();
    end
  endtask

  task automatic test_async_reset();
    cyc = 4'b0010;
    stb = 4'b0010;
    exp_q.push_back(4'b0010);
    step();
    ack = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0 || err !== 4'b0 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst gnt=%b busy=%b owner=%0d err=%b cnt=%0d exp zeros", gnt, busy, owner, err, tcnt);
    end
    ack = 1'b0;
    step();
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    step();
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL post_rst gnt=%b owner=%0d exp 0010/1", gnt, owner);
    end
    cyc = 4'b0000;
    stb = 4'b0000;
    step();
    step();
  endtask

  initial begin
    for (int m = 0; m < 4; m++) cti_m[m] = CTI_CLASSIC;
    test_reset();
    test_rr_order();
    test_burst_preempt();
    test_back_to_back();
    test_watchdog();
    test_ack_wins();
    test_tmo_saturate();
    test_async_reset();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover remaining=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
